// File: rtl/cdc_ctrl_pkg.sv
// Shared types and default sizing for the req/ack clock-crossing controller.
//   state_t      : controller FSM states
//   *_DEF        : default parameter values for the controller and its interface
//   CNT_W        : width of the REQ-phase timeout counter (covers TIMEOUT up to 65535)
package cdc_ctrl_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W       = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_t;

endpackage

// File: rtl/cdc_req_ack_ctrl_if.sv
// Requester bus plus 4-phase crossing handshake for cdc_req_ack_ctrl.
//   i_valid/i_data      : per-requester request and word (word k in i_data[k])
//   o_ready             : one-hot accept strobe
//   o_grant_id          : owner of the current transfer
//   o_req/o_data        : registered 4-phase request and word to the far domain
//   i_ack_async         : far-domain acknowledge (asynchronous)
//   o_busy/o_timeout    : status
// slave = controller view, master = requester/far-side view.
interface cdc_req_ack_ctrl_if import cdc_ctrl_pkg::*; #(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  localparam int GID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]             i_valid;
  logic [N_REQ-1:0][DATA_W-1:0] i_data;
  logic [N_REQ-1:0]             o_ready;
  logic [GID_W-1:0]             o_grant_id;
  logic                         o_req;
  logic [DATA_W-1:0]            o_data;
  logic                         i_ack_async;
  logic                         o_busy;
  logic                         o_timeout;

  modport slave (
    input  i_valid, i_data, i_ack_async,
    output o_ready, o_grant_id, o_req, o_data, o_busy, o_timeout
  );

  modport master (
    output i_valid, i_data, i_ack_async,
    input  o_ready, o_grant_id, o_req, o_data, o_busy, o_timeout
  );

endinterface

// File: rtl/Double_FF_Synch.sv
// Two-flop synchronizer for a single asynchronous level.
//   i_clk   : destination clock
//   i_rst_n : async active-low reset, clears both stages
//   i_D     : asynchronous input
//   o_q     : synchronized output (2-cycle latency)
module Double_FF_Synch (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_D,
  output logic o_q
);

  logic meta;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta <= 1'b0;
      o_q  <= 1'b0;
    end else begin
      meta <= i_D;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/cdc_req_ack_ctrl.sv
// Round-robin arbiter feeding a 4-phase req/ack crossing to another clock domain.
// One winner is accepted in IDLE (o_ready strobe), its word is latched and o_req
// raised on the next edge. The synchronized ack retires the request; ack release
// returns to IDLE. A REQ phase that runs TIMEOUT cycles without ack is aborted.
//   i_clk, i_rst_n : source clock, async active-low reset
//   bus (slave)    : requester bus and crossing handshake, see cdc_req_ack_ctrl_if
module cdc_req_ack_ctrl import cdc_ctrl_pkg::*; #(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  cdc_req_ack_ctrl_if.slave bus
);

  localparam int               GID_W    = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [GID_W-1:0] PTR_RST  = GID_W'(N_REQ - 1);

  state_t           state, nxt;
  logic             ack_s;
  logic [GID_W-1:0] ptr, gnt_idx;
  logic             gnt_any, grant;
  logic [CNT_W-1:0] cnt;
  logic             cnt_done;

  Double_FF_Synch u_ack_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_D     (bus.i_ack_async),
    .o_q     (ack_s)
  );

  // Round-robin search starting just after the last owner.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!gnt_any && bus.i_valid[(int'(ptr) + i) % N_REQ]) begin
        gnt_any = 1'b1;
        gnt_idx = GID_W'((int'(ptr) + i) % N_REQ);
      end
    end
  end

  // A stale ack still high blocks new grants. Reset is folded in so o_ready
  // reads zero for the whole reset window even with requesters active.
  assign grant    = i_rst_n && (state == IDLE) && gnt_any && !ack_s;
  assign cnt_done = (cnt == CNT_LAST);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= nxt;
  end

  // Next state; ack is checked before the timeout so a coincident ack wins.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (grant)              nxt = REQ;
      REQ:     if (ack_s || cnt_done)  nxt = REL;
      REL:     if (!ack_s)             nxt = IDLE;
      default:                         nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.o_busy  = (state != IDLE);
    bus.o_ready = '0;
    if (grant) bus.o_ready[gnt_idx] = 1'b1;
  end

  // Registered transfer datapath, counter and round-robin pointer.
  // o_data/o_grant_id load only on a grant, so they hold through REQ/REL/IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_req      <= 1'b0;
      bus.o_data     <= '0;
      bus.o_grant_id <= '0;
      bus.o_timeout  <= 1'b0;
      ptr            <= PTR_RST;
      cnt            <= '0;
    end else begin
      bus.o_timeout <= 1'b0;
      unique case (state)
        IDLE: if (grant) begin
          bus.o_data     <= bus.i_data[gnt_idx];
          bus.o_grant_id <= gnt_idx;
          bus.o_req      <= 1'b1;
          cnt            <= '0;
        end
        REQ: begin
          if (ack_s) begin
            bus.o_req <= 1'b0;
          end else if (cnt_done) begin
            bus.o_req     <= 1'b0;
            bus.o_timeout <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        REL: if (!ack_s) ptr <= bus.o_grant_id;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_req_ack_ctrl.sv
module tb_cdc_req_ack_ctrl;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  cdc_req_ack_ctrl_if #(.N_REQ(NR), .DATA_W(DW)) bus ();

  cdc_req_ack_ctrl #(.N_REQ(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Accept cycle in IDLE, then the edge that raises o_req with the latched word.
  task automatic grant(input string tag, input int k, input logic [7:0] d);
    logic [3:0] oh;
    oh = 4'b0001 << k;
    #1;
    chk({tag, "_ready"}, 32'(bus.o_ready), 32'(oh));
    chk({tag, "_idle"},  32'(bus.o_busy),  32'd0);
    chk({tag, "_req0"},  32'(bus.o_req),   32'd0);
    tick();
    chk({tag, "_req1"},  32'(bus.o_req),      32'd1);
    chk({tag, "_gid"},   32'(bus.o_grant_id), 32'(k));
    chk({tag, "_data"},  32'(bus.o_data),     32'(d));
    chk({tag, "_rdy0"},  32'(bus.o_ready),    32'd0);
  endtask

  // Ack raise then release; each edge visible 2 cycles late through the synchronizer.
  task automatic ack_cycle(input string tag);
    bus.i_ack_async = 1'b1;
    tick(2);
    chk({tag, "_reqhold"}, 32'(bus.o_req), 32'd1);
    tick();
    chk({tag, "_reqdrop"}, 32'(bus.o_req),     32'd0);
    chk({tag, "_notmo"},   32'(bus.o_timeout), 32'd0);
    chk({tag, "_rel"},     32'(bus.o_busy),    32'd1);
    bus.i_ack_async = 1'b0;
    tick(2);
    chk({tag, "_relhold"}, 32'(bus.o_busy), 32'd1);
    tick();
    chk({tag, "_back"},    32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    rst_n           = 1'b1;
    bus.i_valid     = '0;
    bus.i_data      = '0;
    bus.i_ack_async = 1'b0;
    #2 rst_n = 1'b0;
    tick(2);
    chk("rst_req",   32'(bus.o_req),      32'd0);
    chk("rst_ready", 32'(bus.o_ready),    32'd0);
    chk("rst_data",  32'(bus.o_data),     32'd0);
    chk("rst_gid",   32'(bus.o_grant_id), 32'd0);
    chk("rst_busy",  32'(bus.o_busy),     32'd0);
    chk("rst_tmo",   32'(bus.o_timeout),  32'd0);
    rst_n = 1'b1;

    // Single requester 1, ack 6 cycles after o_req
    bus.i_data  = {8'h44, 8'h33, 8'hA5, 8'h11};
    bus.i_valid = 4'b0010;
    grant("single", 1, 8'hA5);
    bus.i_valid = '0;
    tick(6);
    ack_cycle("single");

    // Contention from a fresh reset: ptr=3 -> 0,1,2,3,0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.i_data  = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    bus.i_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      d = 8'hC0 + 8'(i % 4);
      grant($sformatf("rr%0d", i), i % 4, d);
      tick(2);
      ack_cycle($sformatf("rr%0d", i));
    end
    bus.i_valid = '0;

    // Timeout: o_req high for exactly TO cycles, then one o_timeout pulse
    bus.i_data[2] = 8'h3C;
    bus.i_valid   = 4'b0100;
    grant("tmo", 2, 8'h3C);
    bus.i_valid   = '0;
    tick(TO - 1);
    chk("tmo_last_req", 32'(bus.o_req),     32'd1);
    chk("tmo_not_yet",  32'(bus.o_timeout), 32'd0);
    tick();
    chk("tmo_req_drop", 32'(bus.o_req),     32'd0);
    chk("tmo_pulse",    32'(bus.o_timeout), 32'd1);
    chk("tmo_rel",      32'(bus.o_busy),    32'd1);
    chk("tmo_data",     32'(bus.o_data),    32'h3C);
    tick();
    chk("tmo_pulse_end", 32'(bus.o_timeout), 32'd0);
    chk("tmo_idle",      32'(bus.o_busy),    32'd0);

    // Ack synchronized in the very cycle the counter reaches TO-1: ack wins
    bus.i_data[0] = 8'h81;
    bus.i_valid   = 4'b0001;
    grant("tie", 0, 8'h81);
    bus.i_valid   = '0;
    tick(TO - 3);
    bus.i_ack_async = 1'b1;
    tick(2);
    chk("tie_req_hold", 32'(bus.o_req), 32'd1);
    tick();
    chk("tie_req_drop", 32'(bus.o_req),     32'd0);
    chk("tie_no_tmo",   32'(bus.o_timeout), 32'd0);
    bus.i_ack_async = 1'b0;
    tick(3);
    chk("tie_idle", 32'(bus.o_busy), 32'd0);

    // Stale ack high in IDLE blocks grants until released + 2 sync cycles
    bus.i_ack_async = 1'b1;
    tick(3);
    bus.i_data[0] = 8'h19;
    bus.i_valid   = 4'b0001;
    #1;
    chk("stale_block0", 32'(bus.o_ready), 32'd0);
    tick(2);
    chk("stale_block1", 32'(bus.o_ready), 32'd0);
    chk("stale_busy",   32'(bus.o_busy),  32'd0);
    bus.i_ack_async = 1'b0;
    tick();
    chk("stale_block2", 32'(bus.o_ready), 32'd0);
    tick();
    grant("stale", 0, 8'h19);
    bus.i_valid = '0;
    tick(2);
    ack_cycle("stale");

    // Data stability while inputs churn during REQ/REL
    bus.i_data[3] = 8'h5A;
    bus.i_valid   = 4'b1000;
    grant("stab", 3, 8'h5A);
    bus.i_valid   = '0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < NR; k++) bus.i_data[k] = 8'($urandom);
      bus.i_valid = 4'($urandom);
      tick();
      chk($sformatf("stab_data%0d", i), 32'(bus.o_data),     32'h5A);
      chk($sformatf("stab_gid%0d", i),  32'(bus.o_grant_id), 32'd3);
      bus.i_valid = '0;
    end
    ack_cycle("stab");
    bus.i_data = {8'hEE, 8'hDD, 8'hCC, 8'hBB};
    tick();
    chk("stab_idle_data", 32'(bus.o_data),     32'h5A);
    chk("stab_idle_gid",  32'(bus.o_grant_id), 32'd3);

    // Reset mid-REQ: ptr had moved to 1, must come back at 3
    bus.i_data[1] = 8'h42;
    bus.i_valid   = 4'b0010;
    grant("pre", 1, 8'h42);
    bus.i_valid   = '0;
    tick(2);
    ack_cycle("pre");
    bus.i_data[2] = 8'h24;
    bus.i_valid   = 4'b0100;
    grant("mid", 2, 8'h24);
    tick(2);
    rst_n = 1'b0;
    #1;
    chk("arst_req",   32'(bus.o_req),      32'd0);
    chk("arst_ready", 32'(bus.o_ready),    32'd0);
    chk("arst_data",  32'(bus.o_data),     32'd0);
    chk("arst_gid",   32'(bus.o_grant_id), 32'd0);
    chk("arst_busy",  32'(bus.o_busy),     32'd0);
    chk("arst_tmo",   32'(bus.o_timeout),  32'd0);
    tick();
    rst_n       = 1'b1;
    bus.i_valid = '0;
    tick(3);
    chk("post_req",  32'(bus.o_req),  32'd0);
    chk("post_busy", 32'(bus.o_busy), 32'd0);
    bus.i_data[1] = 8'h61;
    bus.i_valid   = 4'b0110;
    grant("post", 1, 8'h61);
    bus.i_valid   = '0;
    tick(2);
    ack_cycle("post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cdc_req_ack_ctrl.md
CDC_REQ_ACK_CTRL -- requirements
Module: cdc_req_ack_ctrl

Interface
REQ-001 Parameter N_REQ, default 4, number of source requesters sharing the crossing (2..8).
REQ-002 Parameter DATA_W, default 8, width of one transfer word.
REQ-003 Parameter TIMEOUT, default 255, i_clk cycles allowed in REQ before abort (1..65535).
REQ-004 Port i_clk  input  1  sole clock (source domain); all state on its rising edge.
REQ-005 Port i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port i_valid  input  N_REQ  per-requester transfer request, held until accepted.
REQ-007 Port i_data  input  N_REQ*DATA_W  requester k word at bits [k*DATA_W +: DATA_W].
REQ-008 Port o_ready  output  N_REQ  one-hot single-cycle accept strobe to the granted requester.
REQ-009 Port o_grant_id  output  $clog2(N_REQ)  index of the requester owning the current transfer.
REQ-010 Port o_req  output  1  registered 4-phase request to destination domain.
REQ-011 Port o_data  output  DATA_W  registered transfer word, stable while o_req or ack handshake active.
REQ-012 Port i_ack_async  input  1  destination acknowledge, asynchronous to i_clk.
REQ-013 Port o_busy  output  1  high in any state other than IDLE.
REQ-014 Port o_timeout  output  1  single-cycle pulse when a transfer is aborted.

Function
REQ-015 i_ack_async SHALL pass through a two-stage synchronizer; only ack_s (synchronized) drives logic.
REQ-016 FSM states SHALL be IDLE, REQ, REL.
REQ-017 IDLE: when any i_valid is high and ack_s==0, grant round-robin starting at ptr+1 (mod N_REQ); same cycle o_ready[k]=1, next edge latch o_data=i_data[k], o_grant_id=k, o_req=1, go REQ.
REQ-018 IDLE with ack_s==1 SHALL grant nothing until ack_s==0.
REQ-019 Accept to o_req high latency SHALL be exactly 1 cycle.
REQ-020 REQ: on ack_s==1, o_req<=0, go REL.
REQ-021 REQ: timeout counter SHALL clear on REQ entry, increment each REQ cycle; at count==TIMEOUT-1 without ack_s, o_req<=0, o_timeout pulses 1 cycle, go REL.
REQ-022 REL: on ack_s==0, go IDLE and set ptr<=o_grant_id; new grant allowed earliest the cycle after reaching IDLE.
REQ-023 o_data and o_grant_id SHALL not change from REQ entry until the next grant.
REQ-024 Round-robin SHALL wrap: ptr==N_REQ-1 searches from 0; single active requester always granted.
REQ-025 i_valid changes outside the grant cycle SHALL have no effect on the active transfer.
REQ-026 Ack arriving in the same cycle the timeout fires SHALL be treated as ack (no o_timeout).

Reset
REQ-027 While i_rst_n==0: state=IDLE, o_req=0, o_ready=0, o_data=0, o_grant_id=0, o_busy=0, o_timeout=0, ptr=N_REQ-1, counter=0, synchronizer stages=0.
REQ-028 Reset asserted mid-transfer SHALL drop o_req immediately (asynchronously); no transfer resumes after release.

Structure
REQ-029 Package cdc_ctrl_pkg SHALL hold the state enum (IDLE, REQ, REL) and default parameter constants.
REQ-030 Ack synchronization SHALL instantiate the existing Double_FF_Synch (i_clk, i_rst_n, i_D, o_q); no other sub-module.

Verification
REQ-031 Single: i_valid=4'b0010, data1=8'hA5, ack returns 6 cycles after o_req -> o_ready=0010 one cycle, o_req next cycle, o_data=A5, o_grant_id=1, ack_s drops -> IDLE.
REQ-032 Contention: i_valid=4'b1111 held, ptr=3 after reset -> grant order 0,1,2,3,0 across five transfers.
REQ-033 Timeout: TIMEOUT=16, ack never asserted -> o_req falls after 16 REQ cycles, o_timeout one pulse, REL then IDLE.
REQ-034 Stale ack: i_ack_async held high in IDLE with i_valid=0001 -> no o_ready until ack low plus 2-cycle sync delay.
REQ-035 Reset in REQ: assert i_rst_n=0 with o_req=1 -> o_req=0 same time step, all outputs at reset values, ptr=3.
REQ-036 Data stability: change i_data every cycle during REQ/REL -> o_data constant equal to accept-cycle value.
